user_keys_ctrl: RTL

Memory-mapped controller for the eight active-low board user keys, sitting on the bridge next to the other IO devices. It synchronises and debounces each key, keeps a clean pressed-key image, latches press events into a write-1-to-clear pending register, and raises a maskable level interrupt towards the CPU's external interrupt input. It replaces raw key sampling wherever software needs event-driven key input.

---
 rtl/user_keys_ctrl.sv | 110 +++++++++++
 1 files changed

// File: rtl/user_keys_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | user_keys_ctrl: synchronise/debounce 8 active-low keys, W1C press pending, |
// | maskable level irq. Option USER_KEYS_RELEASE_IRQ_EN adds release events.  |
// | Revision 1.0                                                               |
// +----------------------------------------------------------------------------+
module user_keys_ctrl #(
  parameter int DEB_CYCLES = 20000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  Addr,
  input  logic        WE,
  input  logic [31:0] Din,
  output logic [31:0] Dout,
  input  logic [7:0]  user_key,
  output logic        irq
);

`ifdef USER_KEYS_RELEASE_IRQ_EN
  localparam int PW = 16;
`else
  localparam int PW = 8;
`endif
  localparam logic [15:0] CNT_LAST = 16'(DEB_CYCLES - 1);

  localparam logic [1:0] ADDR_PENDING = 2'd1;
  localparam logic [1:0] ADDR_MASK    = 2'd2;
  localparam logic [1:0] ADDR_CTRL    = 2'd3;

  logic [7:0]    sync1;
  logic [7:0]    sync2;
  logic [7:0]    stable;
  logic [7:0]    stable_d;
  logic [PW-1:0] pending;
  logic [PW-1:0] mask;
  logic [PW-1:0] events;
  logic [PW-1:0] clr;
  logic          en;
  logic          unused_din;

  assign unused_din = ^Din[31:PW];

  // Each key matures independently; candidate is the pressed (inverted) level.
  for (genvar i = 0; i < 8; i++) begin : g_deb
    logic [15:0] cnt;
    logic        st;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt <= 16'd0;
        st  <= 1'b0;
      end else if (~sync2[i] == st) begin
        cnt <= 16'd0;
      end else if (cnt == CNT_LAST) begin
        st  <= ~sync2[i];
        cnt <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end

    assign stable[i] = st;
  end

`ifdef USER_KEYS_RELEASE_IRQ_EN
  assign events = {~stable & stable_d, stable & ~stable_d};
`else
  assign events = stable & ~stable_d;
`endif

  assign clr = (WE && (Addr == ADDR_PENDING)) ? Din[PW-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= 8'hFF;
      sync2    <= 8'hFF;
      stable_d <= 8'h00;
      pending  <= '0;
      mask     <= '0;
      en       <= 1'b1;
      irq      <= 1'b0;
    end else begin
      sync1    <= user_key;
      sync2    <= sync1;
      stable_d <= stable;
      // A new event outranks a simultaneous clear of the same bit.
      pending  <= (pending & ~clr) | (en ? events : '0);
      irq      <= |(pending & mask);
      if (WE && (Addr == ADDR_MASK)) begin
        mask <= Din[PW-1:0];
      end
      if (WE && (Addr == ADDR_CTRL)) begin
        en <= Din[0];
      end
    end
  end

  always_comb begin
    Dout = 32'd0;
    case (Addr)
      2'd0:    Dout = {24'd0, stable};
      2'd1:    Dout = 32'(pending);
      2'd2:    Dout = 32'(mask);
      default: Dout = {31'd0, en};
    endcase
  end

endmodule
`default_nettype wire
